// File: rtl/hazard_unit.sv
// hazard_unit: decode-stage hazard detection and operand forwarding select.
//
// Tracks the last DEPTH producers (entry 0 = EX, entry DEPTH-1 = oldest) and
// compares the decode instruction's source fields against their destinations.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   instr_id     decode instruction: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt
//   id_valid     instr_id holds a real instruction
//   flush        taken branch/jump, kills every window entry
//   stall        hold fetch/decode and insert a bubble into EX
//   fwd_a_sel    source for [7:4]:  0 = register file, k+1 = entry k result
//   fwd_b_sel    source for [3:0],  same encoding
//   fwd_c_sel    source for [11:8], same encoding
//   stall_cycles saturating count of stall cycles, cleared only by rst
//
// Build option: define HAZARD_FWD_EN to enable forwarding. Without it every
// select is 0 and any dependency stalls until the producer leaves the window.
module hazard_unit #(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int CW       = 16,
    localparam int FSW     = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [15:0]    instr_id,
    input  logic           id_valid,
    input  logic           flush,
    output logic           stall,
    output logic [FSW-1:0] fwd_a_sel,
    output logic [FSW-1:0] fwd_b_sel,
    output logic [FSW-1:0] fwd_c_sel,
    output logic [CW-1:0]  stall_cycles
);

    if (LOAD_LAT < 0 || LOAD_LAT >= DEPTH) begin : g_bad_load_lat
        $error("hazard_unit: LOAD_LAT must satisfy 0 <= LOAD_LAT < DEPTH");
    end

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SRA  = 4'b0110,
        OP_RL   = 4'b0111,
        OP_LW   = 4'b1000,
        OP_SW   = 4'b1001,
        OP_LHB  = 4'b1010,
        OP_LLB  = 4'b1011,
        OP_B    = 4'b1100,
        OP_JAL  = 4'b1101,
        OP_JR   = 4'b1110,
        OP_EXEC = 4'b1111
    } opcode_t;

    // ---------------- decode of the instruction in ID ----------------
    logic [3:0] op;
    logic [3:0] rd_f;
    logic [3:0] rs_f;
    logic [3:0] rt_f;
    logic       use_a;
    logic       use_b;
    logic       use_c;
    logic       id_writes;

    always_comb begin
        op        = instr_id[15:12];
        rd_f      = instr_id[11:8];
        rs_f      = instr_id[7:4];
        rt_f      = instr_id[3:0];
        use_a     = (op[3:2] == 2'b00) || (op[3:2] == 2'b01) ||
                    (op == OP_LW) || (op == OP_SW);
        use_b     = (op[3:2] == 2'b00);
        use_c     = (op == OP_SW) || (op == OP_LHB) || (op[3:1] == 3'b111);
        id_writes = (op[3:2] != 2'b11) && (op != OP_SW);
    end

    // ---------------- producer window ----------------
    logic [DEPTH-1:0] win_valid;
    logic [DEPTH-1:0] win_writes;
    logic [3:0]       win_rd [DEPTH];
`ifdef HAZARD_FWD_EN
    logic [DEPTH-1:0] win_load;
`endif

    // Youngest matching entry k encoded as k+1, 0 when nothing matches.
    // R0 never matches.
    function automatic logic [FSW-1:0] match_sel(input logic [3:0] src);
        logic [FSW-1:0] sel;
        sel = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            if (sel == '0 && win_valid[j] && win_writes[j] &&
                win_rd[j] == src && src != 4'd0) begin
                sel = FSW'(j + 1);
            end
        end
        return sel;
    endfunction

`ifdef HAZARD_FWD_EN
    // The winning entry is a load whose data is not forwardable yet.
    function automatic logic load_early(input logic [FSW-1:0] sel);
        logic early;
        early = 1'b0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            if (sel == FSW'(j + 1)) begin
                early = win_load[j] && (int'(j) < LOAD_LAT);
            end
        end
        return early;
    endfunction
`endif

    logic [FSW-1:0] sel_a;
    logic [FSW-1:0] sel_b;
    logic [FSW-1:0] sel_c;
    logic           need_a;
    logic           need_b;
    logic           need_c;
    logic           stall_c;

    always_comb begin
        sel_a = match_sel(rs_f);
        sel_b = match_sel(rt_f);
        sel_c = match_sel(rd_f);
`ifdef HAZARD_FWD_EN
        need_a = use_a && load_early(sel_a);
        need_b = use_b && load_early(sel_b);
        need_c = use_c && load_early(sel_c);
`else
        need_a = use_a && (sel_a != '0);
        need_b = use_b && (sel_b != '0);
        need_c = use_c && (sel_c != '0);
`endif
        stall_c = id_valid && (need_a || need_b || need_c);

        fwd_a_sel = '0;
        fwd_b_sel = '0;
        fwd_c_sel = '0;
`ifdef HAZARD_FWD_EN
        if (!stall_c) begin
            fwd_a_sel = use_a ? sel_a : '0;
            fwd_b_sel = use_b ? sel_b : '0;
            fwd_c_sel = use_c ? sel_c : '0;
        end
`endif
    end

    assign stall = stall_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid  <= '0;
            win_writes <= '0;
`ifdef HAZARD_FWD_EN
            win_load   <= '0;
`endif
            for (int unsigned k = 0; k < DEPTH; k++) begin
                win_rd[k] <= '0;
            end
            stall_cycles <= '0;
        end else begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                win_valid[k]  <= win_valid[k-1];
                win_writes[k] <= win_writes[k-1];
                win_rd[k]     <= win_rd[k-1];
`ifdef HAZARD_FWD_EN
                win_load[k]   <= win_load[k-1];
`endif
            end
            // A stalled decode enters EX as a bubble.
            win_valid[0]  <= id_valid && !stall_c;
            win_writes[0] <= id_writes;
            win_rd[0]     <= rd_f;
`ifdef HAZARD_FWD_EN
            win_load[0]   <= (op == OP_LW);
`endif
            // Flush overrides both the shift and the entry-0 load.
            if (flush) begin
                win_valid <= '0;
            end
            if (stall_c && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit (DEPTH=3, LOAD_LAT=1). Expectations are
// selected by HAZARD_FWD_EN so the same bench covers either build.
module tb_hazard_unit;

    localparam int DEPTH = 3;
    localparam int FSW   = 2;
    localparam int CW    = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [15:0]    instr_id = '0;
    logic           id_valid = 1'b0;
    logic           flush = 1'b0;
    logic           stall;
    logic [FSW-1:0] fwd_a_sel;
    logic [FSW-1:0] fwd_b_sel;
    logic [FSW-1:0] fwd_c_sel;
    logic [CW-1:0]  stall_cycles;

    hazard_unit #(.DEPTH(DEPTH), .LOAD_LAT(1), .CW(CW)) dut (
        .clk(clk),
        .rst(rst),
        .instr_id(instr_id),
        .id_valid(id_valid),
        .flush(flush),
        .stall(stall),
        .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel),
        .fwd_c_sel(fwd_c_sel),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [1:0]  a;
        logic [1:0]  b;
        logic [1:0]  c;
        logic [15:0] cyc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [15:0] mk(input int op, input int rd, input int rs, input int rt);
        return {op[3:0], rd[3:0], rs[3:0], rt[3:0]};
    endfunction

    // Monitor: the decode outputs are live every cycle; compare at the
    // falling edge whenever the driver has queued an expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if ({stall, fwd_a_sel, fwd_b_sel, fwd_c_sel, stall_cycles} !==
                {e.st, e.a, e.b, e.c, e.cyc}) begin
                failures++;
                $display("FAIL %s: got stall=%0d a=%0d b=%0d c=%0d cyc=%0d, expected stall=%0d a=%0d b=%0d c=%0d cyc=%0d",
                         e.name, stall, fwd_a_sel, fwd_b_sel, fwd_c_sel, stall_cycles,
                         e.st, e.a, e.b, e.c, e.cyc);
            end
        end
    end

    // Drive one decode cycle and queue its expected response.
    task automatic step(input logic [15:0] ins, input logic v, input logic f, input logic r,
                        input logic est, input int ea, input int eb, input int ec,
                        input int ecyc, input string name);
        exp_t e;
        instr_id = ins;
        id_valid = v;
        flush    = f;
        rst      = r;
        e.st = est; e.a = ea[1:0]; e.b = eb[1:0]; e.c = ec[1:0];
        e.cyc = ecyc[15:0]; e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        flush = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        id_valid = 1'b0;
        flush    = 1'b0;
        instr_id = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    localparam int ADD = 0, SUB = 1, OR_ = 3, LW = 8, SW = 9, LHB = 10;

    initial begin
        logic [15:0] lw31, add435, add211, sub672, add988, or255, sw22, add011, add400, lhb3;
        lw31   = mk(LW, 3, 1, 0);
        add435 = mk(ADD, 4, 3, 5);
        add211 = mk(ADD, 2, 1, 1);
        sub672 = mk(SUB, 6, 7, 2);
        add988 = mk(ADD, 9, 8, 8);
        or255  = mk(OR_, 2, 5, 5);
        sw22   = mk(SW, 2, 2, 0);
        add011 = mk(ADD, 0, 1, 1);
        add400 = mk(ADD, 4, 0, 0);
        lhb3   = mk(LHB, 3, 0, 0);

        @(posedge clk);
        #1;
        do_reset();
        step(16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, "reset_state");

        // Load-use
        do_reset();
        step(lw31,   1, 0, 0, 0, 0, 0, 0, 0, "lw_issue");
        step(add435, 1, 0, 0, 1, 0, 0, 0, 0, "lw_use_stall");
`ifdef HAZARD_FWD_EN
        step(add435, 1, 0, 0, 0, 2, 0, 0, 1, "lw_use_fwd");
        step(16'h0000, 0, 0, 0, 0, 0, 0, 0, 1, "lw_after");
`else
        step(add435, 1, 0, 0, 1, 0, 0, 0, 1, "lw_use_stall2");
        step(add435, 1, 0, 0, 1, 0, 0, 0, 2, "lw_use_stall3");
        step(add435, 1, 0, 0, 0, 0, 0, 0, 3, "lw_use_release");
`endif

        // Back-to-back ALU dependency
        do_reset();
        step(add211, 1, 0, 0, 0, 0, 0, 0, 0, "alu_prod");
`ifdef HAZARD_FWD_EN
        step(sub672, 1, 0, 0, 0, 0, 1, 0, 0, "alu_fwd_ex");
`else
        step(sub672, 1, 0, 0, 1, 0, 0, 0, 0, "alu_stall1");
        step(sub672, 1, 0, 0, 1, 0, 0, 0, 1, "alu_stall2");
        step(sub672, 1, 0, 0, 1, 0, 0, 0, 2, "alu_stall3");
        step(sub672, 1, 0, 0, 0, 0, 0, 0, 3, "alu_release");
`endif

        // One unrelated instruction in between
        do_reset();
        step(add211, 1, 0, 0, 0, 0, 0, 0, 0, "gap_prod");
        step(add988, 1, 0, 0, 0, 0, 0, 0, 0, "gap_filler");
`ifdef HAZARD_FWD_EN
        step(sub672, 1, 0, 0, 0, 0, 2, 0, 0, "gap_fwd_mem");
`else
        step(sub672, 1, 0, 0, 1, 0, 0, 0, 0, "gap_stall1");
        step(sub672, 1, 0, 0, 1, 0, 0, 0, 1, "gap_stall2");
        step(sub672, 1, 0, 0, 0, 0, 0, 0, 2, "gap_release");
`endif

        // Youngest producer wins
        do_reset();
        step(add211, 1, 0, 0, 0, 0, 0, 0, 0, "yw_old");
        step(add988, 1, 0, 0, 0, 0, 0, 0, 0, "yw_filler");
        step(or255,  1, 0, 0, 0, 0, 0, 0, 0, "yw_young");
`ifdef HAZARD_FWD_EN
        step(sw22,   1, 0, 0, 0, 1, 0, 1, 0, "yw_sw_fwd");
`else
        step(sw22,   1, 0, 0, 1, 0, 0, 0, 0, "yw_stall1");
        step(sw22,   1, 0, 0, 1, 0, 0, 0, 1, "yw_stall2");
        step(sw22,   1, 0, 0, 1, 0, 0, 0, 2, "yw_stall3");
        step(sw22,   1, 0, 0, 0, 0, 0, 0, 3, "yw_release");
`endif

        // R0 never matches
        do_reset();
        step(add011, 1, 0, 0, 0, 0, 0, 0, 0, "r0_prod");
        step(add400, 1, 0, 0, 0, 0, 0, 0, 0, "r0_use");

        // Flush during a load-use stall
        do_reset();
        step(lw31, 1, 0, 0, 0, 0, 0, 0, 0, "fl_lw");
        step(lhb3, 1, 1, 0, 1, 0, 0, 0, 0, "fl_stall");
        step(lhb3, 1, 0, 0, 0, 0, 0, 0, 1, "fl_after");

        // Reset during a load-use stall
        do_reset();
        step(lw31, 1, 0, 0, 0, 0, 0, 0, 0, "rs_lw");
        step(lhb3, 1, 0, 1, 1, 0, 0, 0, 0, "rs_stall");
        step(lhb3, 1, 0, 0, 0, 0, 0, 0, 0, "rs_after");

        // Flush together with a valid decode discards it
        do_reset();
        step(add211, 1, 1, 0, 0, 0, 0, 0, 0, "flv_prod");
        step(sub672, 1, 0, 0, 0, 0, 0, 0, 0, "flv_use");

        id_valid = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
